// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC sequencing controller: FSM state
// encoding, bit positions inside the 2-bit mode word, and the hyperbolic
// micro-rotation indices that must be executed twice for convergence.
// ---------------------------------------------------------------------------
package cordic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT1 = 3'd1,
      ST_INIT2 = 3'd2,
      ST_ITER1 = 3'd3,
      ST_ITER2 = 3'd4,
      ST_HOLD  = 3'd5
   } state_t;

   // mode word: bit0 = vectoring (1) / rotation (0), bit1 = hyperbolic (1) / circular (0)
   localparam int unsigned MODE_VEC_BIT = 0;
   localparam int unsigned MODE_HYP_BIT = 1;

   // hyperbolic indices repeated once each
   localparam int unsigned HYP_REP_A = 4;
   localparam int unsigned HYP_REP_B = 13;

endpackage

// File: rtl/cordic_iter_cnt.sv
// ---------------------------------------------------------------------------
// cordic_iter_cnt
// Micro-rotation index counter. Owns the shift / atan-LUT index, the
// hyperbolic repeat flag and detection of the final step.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   load_i          load start index (0 circular, 1 hyperbolic), clear repeat
//   adv_i           advance to the next step
//   hyp_i           hyperbolic sequence select
//   iter_o          current index
//   last_o          current index is the final step of the sequence
// ---------------------------------------------------------------------------
module cordic_iter_cnt
   import cordic_pkg::*;
#(
   parameter  int unsigned N_ITER = 16,
   localparam int unsigned CNT_W  = $clog2(N_ITER + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             adv_i,
   input  logic             hyp_i,
   output logic [CNT_W-1:0] iter_o,
   output logic             last_o
);

   logic [CNT_W-1:0] r_iter;
   logic             r_rep;
   logic [31:0]      w_iter32;
   logic             w_is_rep_idx;
   logic             w_rep_pending;

   // compare at full width so the index 13 cannot alias into a narrow counter
   assign w_iter32      = 32'(r_iter);
   assign w_is_rep_idx  = hyp_i && ((w_iter32 == HYP_REP_A) ||
                                    ((HYP_REP_B <= N_ITER) && (w_iter32 == HYP_REP_B)));
   assign w_rep_pending = w_is_rep_idx && !r_rep;

   assign last_o = hyp_i ? ((w_iter32 == N_ITER) && !w_rep_pending)
                         : (w_iter32 == (N_ITER - 1));
   assign iter_o = r_iter;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_iter <= '0;
         r_rep  <= 1'b0;
      end else if (load_i) begin
         r_iter <= hyp_i ? CNT_W'(1) : '0;
         r_rep  <= 1'b0;
      end else if (adv_i) begin
         if (w_rep_pending) begin
            // second pass over the same index; index held
            r_rep <= 1'b1;
         end else begin
            r_iter <= r_iter + CNT_W'(1);
            r_rep  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cordic_ctrl.sv
// ---------------------------------------------------------------------------
// cordic_ctrl
// Sequencing controller for an iterative two-stage CORDIC datapath.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   start_i         start request (accepted only in IDLE)
//   mode_i          {hyperbolic, vectoring}, latched on accepted start
//   abort_i         synchronous cancel of the running operation
//   sign_i          datapath sign (z MSB rotation, y MSB vectoring)
//   out_ready_i     consumer takes the held result
//   ready_o         idle
//   busy_o          operation in progress
//   sel_o           datapath mux: 0 initial operands, 1 feedback
//   ena1_o, ena2_o  stage-1 / stage-2 register enables
//   iter_o          shift / atan-LUT index
//   mode_o          latched mode
//   sigma_o         rotation direction (1 = +1)
//   done_tick_o     pulse on the final stage-2 cycle
//   valid_o         result held and valid
// ---------------------------------------------------------------------------
module cordic_ctrl
   import cordic_pkg::*;
#(
   parameter  int unsigned N_ITER = 16,
   localparam int unsigned CNT_W  = $clog2(N_ITER + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [1:0]       mode_i,
   input  logic             abort_i,
   input  logic             sign_i,
   input  logic             out_ready_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic             sel_o,
   output logic             ena1_o,
   output logic             ena2_o,
   output logic [CNT_W-1:0] iter_o,
   output logic [1:0]       mode_o,
   output logic             sigma_o,
   output logic             done_tick_o,
   output logic             valid_o
);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [1:0] r_mode;
   logic       w_accept;
   logic       w_load;
   logic       w_adv;
   logic       w_last;

   cordic_iter_cnt #(
      .N_ITER (N_ITER)
   ) u_iter_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (w_load),
      .adv_i  (w_adv),
      .hyp_i  (r_mode[MODE_HYP_BIT]),
      .iter_o (iter_o),
      .last_o (w_last)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
         r_mode  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_mode <= mode_i;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_load      = 1'b0;
      w_adv       = 1'b0;
      ready_o     = 1'b0;
      busy_o      = 1'b0;
      sel_o       = 1'b0;
      ena1_o      = 1'b0;
      ena2_o      = 1'b0;
      done_tick_o = 1'b0;
      valid_o     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            ready_o = 1'b1;
            // start coincident with abort is dropped
            if (start_i && !abort_i) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_INIT1;
            end
         end
         ST_INIT1: begin
            busy_o      = 1'b1;
            ena1_o      = 1'b1;
            w_state_nxt = ST_INIT2;
         end
         ST_INIT2: begin
            busy_o      = 1'b1;
            ena2_o      = 1'b1;
            w_load      = 1'b1;
            w_state_nxt = ST_ITER1;
         end
         ST_ITER1: begin
            busy_o      = 1'b1;
            sel_o       = 1'b1;
            ena1_o      = 1'b1;
            w_state_nxt = ST_ITER2;
         end
         ST_ITER2: begin
            busy_o = 1'b1;
            sel_o  = 1'b1;
            ena2_o = 1'b1;
            if (w_last) begin
               done_tick_o = !abort_i;
               w_state_nxt = ST_HOLD;
            end else begin
               w_adv       = 1'b1;
               w_state_nxt = ST_ITER1;
            end
         end
         ST_HOLD: begin
            valid_o = 1'b1;
            sel_o   = 1'b1;
            if (out_ready_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (abort_i && (r_state != ST_IDLE)) begin
         w_state_nxt = ST_IDLE;
      end
   end

   assign mode_o  = r_mode;
   assign sigma_o = r_mode[MODE_VEC_BIT] ? sign_i : ~sign_i;

endmodule
